// File: rtl/tick_timer_pkg.sv
// Shared definitions for the Runner elapsed-time counter: FSM states,
// BCD digit limits and packed-BCD constants for saturation and the alarm limit.
package tick_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic [3:0] BCD_MAX_NINE = 4'd9;
   localparam logic [3:0] BCD_MAX_FIVE = 4'd5;

   // Packed as {minutes, sec_tens, sec_ones, tenths}
   localparam logic [15:0] COUNT_SAT     = 16'h9599;
   localparam logic [15:0] COUNT_PRE_SAT = 16'h9598;

   function automatic logic [15:0] limit_bcd(input int min_val, input int sec_val);
      logic [3:0] m;
      logic [3:0] t;
      logic [3:0] o;
      m = 4'(min_val);
      t = 4'(sec_val / 10);
      o = 4'(sec_val % 10);
      return {m, t, o, 4'd0};
   endfunction

endpackage

// File: rtl/tick_timer_if.sv
// Connection between a controller (tick source plus control buttons) and the
// elapsed-time counter, including the BCD digits and status flags it returns.
interface tick_timer_if;

   logic       tick;
   logic       start;
   logic       pause;
   logic       clear;
   logic [3:0] tenths;
   logic [3:0] sec_ones;
   logic [3:0] sec_tens;
   logic [3:0] minutes;
   logic       running;
   logic       alarm;
   logic       full;
   logic       step;

   modport master (
      output tick, start, pause, clear,
      input  tenths, sec_ones, sec_tens, minutes, running, alarm, full, step
   );

   modport slave (
      input  tick, start, pause, clear,
      output tenths, sec_ones, sec_tens, minutes, running, alarm, full, step
   );

endinterface

// File: rtl/tick_timer_bcd_digit.sv
// One BCD digit that wraps at MAX; carry is combinational so digits chain
// into a ripple counter that advances in a single cycle.
module bcd_digit #(
   parameter logic [3:0] MAX = 4'd9
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       inc,
   input  logic       clr,
   output logic [3:0] digit,
   output logic       carry
);

   logic [3:0] digit_q;
   logic [3:0] digit_d;

   always_comb begin
      digit_d = digit_q;
      if (clr) begin
         digit_d = 4'd0;
      end else if (inc) begin
         digit_d = (digit_q == MAX) ? 4'd0 : digit_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         digit_q <= 4'd0;
      end else begin
         digit_q <= digit_d;
      end
   end

   assign digit = digit_q;
   assign carry = inc & (digit_q == MAX);

endmodule

// File: rtl/tick_timer.sv
// Runner elapsed-time counter: edge-detects the 100 ms tick and accumulates
// m:ss.t in BCD under a start/pause/clear FSM, with a sticky time-limit alarm.
module tick_timer
   import tick_timer_pkg::*;
#(
   parameter int LIMIT_MIN = 1,
   parameter int LIMIT_SEC = 30
) (
   input  logic         clk,
   input  logic         reset_n,
   tick_timer_if.slave  bus
);

   localparam logic [15:0] LIMIT = limit_bcd(LIMIT_MIN, LIMIT_SEC);

   state_e     state_q;
   state_e     state_d;
   logic       tick_q;
   logic       tick_d;
   logic       alarm_q;
   logic       alarm_d;
   logic       step_q;
   logic       step_d;

   logic [3:0] tenths;
   logic [3:0] sec_ones;
   logic [3:0] sec_tens;
   logic [3:0] minutes;
   logic       tenths_carry;
   logic       ones_carry;
   logic       tens_carry;
   logic       minutes_carry_unused;
   logic [15:0] count;
   logic       tick_edge;
   logic       count_en;

   assign count     = {minutes, sec_tens, sec_ones, tenths};
   assign tick_edge = bus.tick & ~tick_q;
   // Judged against the registered state, so an edge alongside start is dropped
   assign count_en  = tick_edge && (state_q == ST_RUN) && !bus.clear
                      && (count != COUNT_SAT);

   bcd_digit #(.MAX(BCD_MAX_NINE)) u_tenths (
      .clk(clk), .reset_n(reset_n), .inc(count_en), .clr(bus.clear),
      .digit(tenths), .carry(tenths_carry)
   );
   bcd_digit #(.MAX(BCD_MAX_NINE)) u_sec_ones (
      .clk(clk), .reset_n(reset_n), .inc(tenths_carry), .clr(bus.clear),
      .digit(sec_ones), .carry(ones_carry)
   );
   bcd_digit #(.MAX(BCD_MAX_FIVE)) u_sec_tens (
      .clk(clk), .reset_n(reset_n), .inc(ones_carry), .clr(bus.clear),
      .digit(sec_tens), .carry(tens_carry)
   );
   bcd_digit #(.MAX(BCD_MAX_NINE)) u_minutes (
      .clk(clk), .reset_n(reset_n), .inc(tens_carry), .clr(bus.clear),
      .digit(minutes), .carry(minutes_carry_unused)
   );

   always_comb begin
      tick_d  = bus.tick;
      step_d  = count_en;
      alarm_d = alarm_q | (count == LIMIT);
      state_d = state_q;
      if (bus.clear) begin
         state_d = ST_IDLE;
         alarm_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_RUN;
            // Reaching saturation wins over a coincident pause
            ST_RUN: begin
               if (count_en && (count == COUNT_PRE_SAT)) begin
                  state_d = ST_DONE;
               end else if (bus.pause) begin
                  state_d = ST_PAUSE;
               end
            end
            ST_PAUSE: if (!bus.pause && bus.start) state_d = ST_RUN;
            default:  state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         tick_q  <= 1'b1;
         alarm_q <= 1'b0;
         step_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         alarm_q <= alarm_d;
         step_q  <= step_d;
      end
   end

   assign bus.tenths   = tenths;
   assign bus.sec_ones = sec_ones;
   assign bus.sec_tens = sec_tens;
   assign bus.minutes  = minutes;
   assign bus.running  = (state_q == ST_RUN);
   assign bus.full     = (state_q == ST_DONE);
   assign bus.alarm    = alarm_q;
   assign bus.step     = step_q;

endmodule

// File: tb/tb_tick_timer.sv
// Directed bench for tick_timer: each step drives controls/ticks and compares
// the BCD count and flags against hand-computed values.
module tb_tick_timer;

   logic clk = 1'b0;
   logic reset_n;
   int   tests = 0;
   int   fails = 0;
   int   step_cnt = 0;
   int   step_base;

   tick_timer_if bus ();

   tick_timer #(.LIMIT_MIN(1), .LIMIT_SEC(30)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   // Step pulses last one cycle; sampling on the falling edge counts each once
   always @(negedge clk) begin
      if (bus.step === 1'b1) step_cnt++;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic tick_pulses(input int n);
      for (int i = 0; i < n; i++) begin
         bus.tick = 1'b1;
         cyc(1);
         bus.tick = 1'b0;
         cyc(1);
      end
   endtask

   task automatic apply_stimulus(input logic s, input logic p, input logic c, input logic t);
      bus.start = s;
      bus.pause = p;
      bus.clear = c;
      bus.tick  = t;
      cyc(1);
      bus.start = 1'b0;
      bus.pause = 1'b0;
      bus.clear = 1'b0;
      bus.tick  = 1'b0;
      cyc(1);
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] count_now();
      return {16'd0, bus.minutes, bus.sec_tens, bus.sec_ones, bus.tenths};
   endfunction

   initial begin
      reset_n   = 1'b0;
      bus.tick  = 1'b1;
      bus.start = 1'b0;
      bus.pause = 1'b0;
      bus.clear = 1'b0;
      cyc(3);
      check_output("reset_count", count_now(), 32'h0000);
      check_output("reset_flags", {28'd0, bus.running, bus.alarm, bus.full, bus.step}, 32'h0);

      // Release reset with tick already high: no edge, then one real edge
      reset_n = 1'b1;
      cyc(2);
      bus.start = 1'b1;
      cyc(1);
      bus.start = 1'b0;
      cyc(2);
      check_output("held_tick_count", count_now(), 32'h0000);
      check_output("held_tick_steps", step_cnt, 0);
      check_output("running_after_start", {31'd0, bus.running}, 32'h1);
      bus.tick = 1'b0;
      cyc(1);
      bus.tick = 1'b1;
      cyc(1);
      check_output("first_edge_step", {31'd0, bus.step}, 32'h1);
      bus.tick = 1'b0;
      cyc(1);
      check_output("first_edge_count", count_now(), 32'h0001);
      check_output("first_edge_steps", step_cnt, 1);
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
      check_output("clear_count", count_now(), 32'h0000);
      check_output("clear_idle", {31'd0, bus.running}, 32'h0);

      // Long run to the alarm limit 1:30.0
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tick_pulses(600);
      check_output("count_1m", count_now(), 32'h1000);
      check_output("alarm_low_1m", {31'd0, bus.alarm}, 32'h0);
      tick_pulses(299);
      check_output("count_899", count_now(), 32'h1299);
      check_output("alarm_low_899", {31'd0, bus.alarm}, 32'h0);
      tick_pulses(1);
      check_output("count_900", count_now(), 32'h1300);
      check_output("alarm_high_900", {31'd0, bus.alarm}, 32'h1);
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
      check_output("alarm_cleared", {31'd0, bus.alarm}, 32'h0);

      // Pause and resume
      step_base = step_cnt;
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tick_pulses(5);
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
      check_output("paused_not_running", {31'd0, bus.running}, 32'h0);
      tick_pulses(3);
      check_output("paused_count", count_now(), 32'h0005);
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tick_pulses(2);
      check_output("resume_count", count_now(), 32'h0007);
      check_output("resume_steps", step_cnt - step_base, 7);
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);

      // Saturation at 9:59.9
      step_base = step_cnt;
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tick_pulses(5998);
      check_output("count_pre_sat", count_now(), 32'h9598);
      check_output("full_low_pre_sat", {31'd0, bus.full}, 32'h0);
      tick_pulses(1);
      check_output("count_sat", count_now(), 32'h9599);
      check_output("sat_flags", {29'd0, bus.running, bus.alarm, bus.full}, 32'h3);
      check_output("sat_steps", step_cnt - step_base, 5999);
      step_base = step_cnt;
      tick_pulses(5);
      check_output("sat_hold_count", count_now(), 32'h9599);
      check_output("sat_hold_steps", step_cnt - step_base, 0);
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
      check_output("sat_clear_count", count_now(), 32'h0000);
      check_output("sat_clear_flags", {29'd0, bus.running, bus.alarm, bus.full}, 32'h0);

      // Coincident control and tick edges
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1);
      check_output("start_edge_count", count_now(), 32'h0000);
      check_output("start_edge_running", {31'd0, bus.running}, 32'h1);
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1);
      check_output("pause_edge_count", count_now(), 32'h0001);
      check_output("pause_edge_running", {31'd0, bus.running}, 32'h0);
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
      bus.tick = 1'b1;
      cyc(5);
      bus.tick = 1'b0;
      cyc(1);
      check_output("long_tick_count", count_now(), 32'h0002);
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1);
      check_output("clear_edge_count", count_now(), 32'h0000);

      // Reset mid-count while an edge and start are present
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tick_pulses(453);
      check_output("count_45_3", count_now(), 32'h0453);
      reset_n   = 1'b0;
      bus.start = 1'b1;
      bus.tick  = 1'b1;
      cyc(1);
      check_output("midreset_count", count_now(), 32'h0000);
      check_output("midreset_flags", {28'd0, bus.running, bus.alarm, bus.full, bus.step}, 32'h0);
      bus.start = 1'b0;
      bus.tick  = 1'b0;
      reset_n   = 1'b1;
      cyc(2);
      check_output("post_reset_idle", {31'd0, bus.running}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
